// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU-side and memory-side buses of the L1 data cache.
// The controller uses the master view; the CPU/memory environment uses the slave view.
interface dcache_controller_if #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 256
);
    logic [ADDR_W-1:0]     cpu_addr_i;
    logic                  cpu_memread_i;
    logic                  cpu_memwrite_i;
    logic [31:0]           cpu_data_i;
    logic [31:0]           cpu_data_o;
    logic                  cpu_stall_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport master (
        input  cpu_addr_i, cpu_memread_i, cpu_memwrite_i, cpu_data_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport slave (
        output cpu_addr_i, cpu_memread_i, cpu_memwrite_i, cpu_data_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Hits complete combinationally in IDLE; a miss walks WRITEBACK (if dirty),
// ALLOCATE and a one-cycle REFILL, after which the held request re-looks-up and hits.
module dcache_controller #(
    parameter int LINES      = 16,
    parameter int BLOCK_BITS = 256,
    parameter int ADDR_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.master bus
);
    localparam int WORDS  = BLOCK_BITS / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    logic [1:0]            r_state;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [WSEL_W-1:0]     w_wsel;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_store;
    logic [BLOCK_BITS-1:0] w_line;
    logic [31:0]           w_word;
    logic                  w_unused;

    // Request fields are decoded live; the CPU holds them stable while stalled.
    assign w_idx    = bus.cpu_addr_i[OFF_W +: IDX_W];
    assign w_tag    = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel   = bus.cpu_addr_i[2 +: WSEL_W];
    assign w_unused = &{1'b0, bus.cpu_addr_i[1:0]};
    assign w_req    = bus.cpu_memread_i | bus.cpu_memwrite_i;
    assign w_store  = bus.cpu_memwrite_i;
    assign w_hit    = (r_state == S_IDLE) & w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss   = (r_state == S_IDLE) & w_req & ~w_hit;
    assign w_line   = r_data[w_idx];
    assign w_word   = w_line[{w_wsel, 5'b00000} +: 32];

    // Miss sequencing: optional write-back, then fetch, then one settle cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss)
                        r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i)
                        r_state <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (bus.mem_ack_i)
                        r_state <= S_REFILL;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line status bits: the only cache state cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_hit && w_store)
                r_dirty[w_idx] <= 1'b1;
            if (r_state == S_WRITEBACK && bus.mem_ack_i)
                r_dirty[w_idx] <= 1'b0;
            if (r_state == S_ALLOCATE && bus.mem_ack_i) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays: store-hit word merge and block fill, never reset.
    always_ff @(posedge clk_i) begin
        if (w_hit && w_store)
            r_data[w_idx][{w_wsel, 5'b00000} +: 32] <= bus.cpu_data_i;
        if (r_state == S_ALLOCATE && bus.mem_ack_i) begin
            r_data[w_idx] <= bus.mem_data_i;
            r_tag[w_idx]  <= w_tag;
        end
    end

    // Outputs; stall is gated by reset so an abandoned miss releases the pipeline at once.
    always_comb begin
        bus.cpu_data_o   = '0;
        bus.cpu_stall_o  = 1'b0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        if (w_hit && bus.cpu_memread_i)
            bus.cpu_data_o = w_word;
        if (rst_i && ((r_state != S_IDLE) || w_miss))
            bus.cpu_stall_o = 1'b1;
        case (r_state)
            S_WRITEBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                bus.mem_data_o   = w_line;
            end
            S_ALLOCATE: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed vectors against a fixed-latency block memory model.
module tb_dcache_controller;
    localparam int LAT = 10;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dcache_controller_if #(.ADDR_W(32), .BLOCK_BITS(256)) bus ();

    dcache_controller #(.LINES(16), .BLOCK_BITS(256), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: block b word w holds 0x1000_0000 + 16*b + w, except block 8 word 1.
    logic [255:0] mem_blk [64];
    int           cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= 0;
            bus.mem_ack_i  <= 1'b0;
            bus.mem_data_i <= '0;
            for (int b = 0; b < 64; b++)
                for (int w = 0; w < 8; w++)
                    mem_blk[b][w*32 +: 32] <= 32'h1000_0000 + 32'(b*16 + w);
            mem_blk[8][63:32] <= 32'hDEAD_BEEF;
        end else begin
            bus.mem_ack_i <= 1'b0;
            if (bus.mem_enable_o && !bus.mem_ack_i) begin
                if (cnt == LAT-2) begin
                    cnt           <= 0;
                    bus.mem_ack_i <= 1'b1;
                    if (!bus.mem_write_o)
                        bus.mem_data_i <= mem_blk[bus.mem_addr_o[10:5]];
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
            if (bus.mem_enable_o && bus.mem_ack_i && bus.mem_write_o)
                mem_blk[bus.mem_addr_o[10:5]] <= bus.mem_data_o;
        end
    end

    // Transfer log: one entry per acknowledged block transfer.
    logic [31:0]  xl_addr [64];
    logic         xl_wr   [64];
    logic [255:0] xl_data [64];
    int           xcnt = 0;
    always @(posedge clk) begin
        if (bus.mem_enable_o && bus.mem_ack_i && xcnt < 64) begin
            xl_addr[xcnt] <= bus.mem_addr_o;
            xl_wr[xcnt]   <= bus.mem_write_o;
            xl_data[xcnt] <= bus.mem_data_o;
            xcnt          <= xcnt + 1;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        int          stalls;
        logic        chk_data;
        logic [31:0] rdata;
        logic        has_wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_word;
        logic        has_fetch;
        logic [31:0] fetch_addr;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_access(input int n, input vec_t v);
        int          stalls;
        int          x0;
        int          nx;
        int          fi;
        logic [31:0] wbw;
        string       tg;
        tg = $sformatf("v%0d", n);
        x0 = xcnt;
        stalls = 0;
        @(posedge clk); #1;
        bus.cpu_addr_i     = v.addr;
        bus.cpu_memread_i  = v.rd;
        bus.cpu_memwrite_i = v.wr;
        bus.cpu_data_i     = v.wdata;
        @(negedge clk);
        while (bus.cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        chk({tg, " stall cycles"}, 32'(stalls), 32'(v.stalls));
        if (v.chk_data)
            chk({tg, " load data"}, bus.cpu_data_o, v.rdata);
        nx = xcnt - x0;
        chk({tg, " transfer count"}, 32'(nx), 32'(int'(v.has_wb) + int'(v.has_fetch)));
        if (v.has_wb && nx >= 1) begin
            wbw = xl_data[x0][{v.addr[4:2], 5'b00000} +: 32];
            chk({tg, " wb is write"}, 32'(xl_wr[x0]), 32'd1);
            chk({tg, " wb addr"}, xl_addr[x0], v.wb_addr);
            chk({tg, " wb word"}, wbw, v.wb_word);
        end
        fi = x0 + int'(v.has_wb);
        if (v.has_fetch && nx > int'(v.has_wb)) begin
            chk({tg, " fetch is read"}, 32'(xl_wr[fi]), 32'd0);
            chk({tg, " fetch addr"}, xl_addr[fi], v.fetch_addr);
        end
        @(posedge clk); #1;
        bus.cpu_memread_i  = 1'b0;
        bus.cpu_memwrite_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   waited;
        vec_t vr;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.cpu_addr_i     = '0;
        bus.cpu_memread_i  = 1'b0;
        bus.cpu_memwrite_i = 1'b0;
        bus.cpu_data_i     = '0;

        //        addr        rd wr wdata         st chk rdata         wb wb_addr      wb_word       f  f_addr
        vt[0]  = '{32'h104, 1, 0, 32'h0,        12, 1, 32'hDEADBEEF, 0, 32'h0,     32'h0,        1, 32'h100};
        vt[1]  = '{32'h108, 1, 0, 32'h0,         0, 1, 32'h10000082, 0, 32'h0,     32'h0,        0, 32'h0};
        vt[2]  = '{32'h104, 0, 1, 32'h12345678,  0, 1, 32'h0,        0, 32'h0,     32'h0,        0, 32'h0};
        vt[3]  = '{32'h304, 1, 0, 32'h0,        22, 1, 32'h10000181, 1, 32'h100,   32'h12345678, 1, 32'h300};
        vt[4]  = '{32'h040, 0, 1, 32'hA5A5A5A5, 12, 1, 32'h0,        0, 32'h0,     32'h0,        1, 32'h040};
        vt[5]  = '{32'h040, 1, 0, 32'h0,         0, 1, 32'hA5A5A5A5, 0, 32'h0,     32'h0,        0, 32'h0};
        vt[6]  = '{32'h104, 1, 0, 32'h0,        12, 1, 32'h12345678, 0, 32'h0,     32'h0,        1, 32'h100};
        vt[7]  = '{32'h104, 1, 1, 32'h1,         0, 0, 32'h0,        0, 32'h0,     32'h0,        0, 32'h0};
        vt[8]  = '{32'h104, 1, 0, 32'h0,         0, 1, 32'h1,        0, 32'h0,     32'h0,        0, 32'h0};
        vt[9]  = '{32'h240, 1, 0, 32'h0,        22, 1, 32'h10000120, 1, 32'h040,   32'hA5A5A5A5, 1, 32'h240};
        vt[10] = '{32'h108, 1, 0, 32'h0,         0, 1, 32'h10000082, 0, 32'h0,     32'h0,        0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(bus.cpu_stall_o), 32'd0);
        chk("reset data", bus.cpu_data_o, 32'h0);
        chk("reset enable", 32'(bus.mem_enable_o), 32'd0);
        chk("reset write", 32'(bus.mem_write_o), 32'd0);
        chk("reset addr", bus.mem_addr_o, 32'h0);
        chk("reset wdata", 32'(bus.mem_data_o != '0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle stall", 32'(bus.cpu_stall_o), 32'd0);

        for (int i = 0; i < 11; i++)
            do_access(i, vt[i]);

        // Reset in the middle of a clean fill of cold index 5.
        @(posedge clk); #1;
        bus.cpu_addr_i    = 32'h0A0;
        bus.cpu_memread_i = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.mem_enable_o && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("midrst enable seen", 32'(bus.mem_enable_o), 32'd1);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst enable", 32'(bus.mem_enable_o), 32'd0);
        chk("midrst stall", 32'(bus.cpu_stall_o), 32'd0);
        bus.cpu_memread_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vr = '{32'h0A0, 1, 0, 32'h0, 12, 1, 32'h10000050, 0, 32'h0, 32'h0, 1, 32'h0A0};
        do_access(11, vr);
        // Reset also invalidated index 8, so a previous hit now misses cleanly.
        vr = '{32'h108, 1, 0, 32'h0, 12, 1, 32'h10000082, 0, 32'h0, 32'h0, 1, 32'h100};
        do_access(12, vr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
